// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    localparam int ENTRY_RD_W = 5;
    localparam logic [ENTRY_RD_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [ENTRY_RD_W-1:0] rd;
        logic                  wb_en;
        logic                  from_mem;
    } stage_entry_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    localparam stage_entry_t ENTRY_NONE = '0;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - RAW match of one in-flight writer against one ID source register
module hazard_match
    import hazard_pkg::*;
(
    input  stage_entry_t          entry,
    input  logic [ENTRY_RD_W-1:0] rs,
    input  logic                  use_rs,
    output logic                  match
);

    // The load flag does not affect the match itself; callers qualify with it.
    logic unused_from_mem;
    assign unused_from_mem = entry.from_mem;

    assign match = use_rs && entry.valid && entry.wb_en
                && (entry.rd != REG_ZERO) && (entry.rd == rs);

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/bubble/flush/freeze and forwarding control; HAZARD_FORWARDING_EN enables operand forwarding
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_writeback_en,
    input  logic                  id_writeback_from_mem,
    input  logic                  ex_redirect,
    input  logic                  mem_busy,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic                  freeze,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    stage_entry_t          ex_q, mem_q, wb_q, id_entry;
    logic [ENTRY_RD_W-1:0] rs1, rs2;
    logic                  use1, use2;
    logic                  ex_m1, ex_m2, mem_m1, mem_m2;
    logic                  hazard;
    logic                  unused_bits;

    assign rs1  = ENTRY_RD_W'(id_rs1_addr);
    assign rs2  = ENTRY_RD_W'(id_rs2_addr);
    assign use1 = id_valid && id_use_rs1;
    assign use2 = id_valid && id_use_rs2;

    assign id_entry = '{valid:    id_valid,
                        rd:       ENTRY_RD_W'(id_rd_addr),
                        wb_en:    id_writeback_en,
                        from_mem: id_writeback_from_mem};

    // The register file is write-through, so the WB entry never needs a comparator.
    hazard_match u_ex_rs1  (.entry(ex_q),  .rs(rs1), .use_rs(use1), .match(ex_m1));
    hazard_match u_ex_rs2  (.entry(ex_q),  .rs(rs2), .use_rs(use2), .match(ex_m2));
    hazard_match u_mem_rs1 (.entry(mem_q), .rs(rs1), .use_rs(use1), .match(mem_m1));
    hazard_match u_mem_rs2 (.entry(mem_q), .rs(rs2), .use_rs(use2), .match(mem_m2));

    assign freeze = mem_busy;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (!mem_busy) begin
            if (ex_redirect) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= ENTRY_NONE;
            mem_q        <= ENTRY_NONE;
            wb_q         <= ENTRY_NONE;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (!freeze) begin
            wb_q         <= mem_q;
            mem_q        <= ex_q;
            ex_q         <= bubble_ex ? ENTRY_NONE : id_entry;
            stall_cycles <= stall_cycles + CNT_W'(stall_id);
            flush_count  <= flush_count + CNT_W'(flush_id);
        end
    end

`ifdef HAZARD_FORWARDING_EN
    fwd_sel_t fwd1_d, fwd2_d, fwd1_q, fwd2_q;

    // Only a load still in EX cannot be forwarded in time.
    assign hazard = (ex_m1 || ex_m2) && ex_q.from_mem;

    // The EX producer will sit in MEM when this instruction reaches EX; youngest wins.
    always_comb begin
        fwd1_d = FWD_REG;
        fwd2_d = FWD_REG;
        if (!bubble_ex) begin
            if (ex_m1)       fwd1_d = FWD_MEM;
            else if (mem_m1) fwd1_d = FWD_WB;
            if (ex_m2)       fwd2_d = FWD_MEM;
            else if (mem_m2) fwd2_d = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd1_q <= FWD_REG;
            fwd2_q <= FWD_REG;
        end else if (!freeze) begin
            fwd1_q <= fwd1_d;
            fwd2_q <= fwd2_d;
        end
    end

    assign fwd_rs1_sel = fwd1_q;
    assign fwd_rs2_sel = fwd2_q;
    assign unused_bits = ^{wb_q, mem_q.from_mem};
`else
    // Without forwarding the consumer waits until its producer reaches WB.
    assign hazard      = ex_m1 || ex_m2 || mem_m1 || mem_m2;
    assign fwd_rs1_sel = FWD_REG;
    assign fwd_rs2_sel = FWD_REG;
    assign unused_bits = ^{wb_q, mem_q.from_mem, ex_q.from_mem};
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Consumes the ID-stage decode fields: register addresses, use_rs1/use_rs2, writeback_en, writeback_from_mem.
- Tracks in-flight writers in EX, MEM and WB, and drives the pipeline control: stall, bubble, flush and forwarding selects.
- Also absorbs multi-cycle memory waits and EX-stage control redirects.

Parameters:
- REG_ADDR_W, 5, register address width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  the ID stage holds a real instruction
- id_rs1_addr  in  REG_ADDR_W  source register 1 of the ID instruction
- id_rs2_addr  in  REG_ADDR_W  source register 2 of the ID instruction
- id_use_rs1  in  1  the ID instruction reads rs1
- id_use_rs2  in  1  the ID instruction reads rs2
- id_rd_addr  in  REG_ADDR_W  destination register of the ID instruction
- id_writeback_en  in  1  the ID instruction writes rd
- id_writeback_from_mem  in  1  the ID instruction is a load
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- mem_busy  in  1  data memory not ready; freeze the whole pipeline
- stall_if  out  1  hold the PC and the IF/ID register
- stall_id  out  1  hold the ID instruction; do not advance it to EX
- bubble_ex  out  1  load a NOP into ID/EX
- flush_id  out  1  squash the IF/ID register
- freeze  out  1  hold all pipeline registers
- fwd_rs1_sel  out  2  EX operand 1 source: 0 regfile, 1 MEM result, 2 WB result
- fwd_rs2_sel  out  2  EX operand 2 source, same encoding
- stall_cycles  out  CNT_W  count of cycles with stall_id=1
- flush_count  out  CNT_W  count of cycles with flush_id=1

Behaviour:
- Reset: clk and rst only, synchronous. All tracking entries are invalid. Every output is 0, including both counters.
- Tracking: each stage entry (EX, MEM, WB) holds {valid, rd, wb_en, from_mem}.
- Normal advance (freeze=0), every clock: WB<=MEM, MEM<=EX. EX<=ID fields, or an invalid entry if bubble_ex=1.
- Matching: an entry "matches" rs when all of the following hold: valid, wb_en, rd!=0, rd==rs, and the corresponding use_rsN=1 with id_valid=1.
- Register file: write-through, so a WB-stage match never causes a hazard.
- Combinational outputs, with priority freeze > redirect > stall:
  - freeze = mem_busy. Nothing advances. Counters and fwd selects hold. All other outputs are 0.
  - Redirect (ex_redirect=1 and mem_busy=0): flush_id=1 and bubble_ex=1; stall_if=0 and stall_id=0. The ID instruction is discarded, so no stall is raised for it even if hazardous.
  - Stall: stall_if=stall_id=bubble_ex=1 when the hazard condition holds (see Optional Feature).
- Forwarding selects are registered and valid during the cycle the instruction occupies EX. They are computed when the ID instruction advances (freeze=0, bubble_ex=0):
  - sel=1 if the current EX entry matches. That producer will be in MEM.
  - Otherwise sel=2 if the current MEM entry matches.
  - Otherwise 0.
  - EX takes priority over MEM (youngest writer wins).
  - A bubble loads sel=0.
- Counters: wrap modulo 2^CNT_W. Increment on cycles with freeze=0 and the respective output high.
- Reset asserted mid-stall or mid-freeze: all state clears on the next edge. No residual stall follows reset.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: hazard = an EX entry with from_mem=1 matches (load-use), giving a single 1-cycle stall. All other RAW dependences are forwarded.
- Undefined:
  - fwd selects are tied to 0.
  - hazard = any EX or MEM entry matches.
  - The stall repeats each cycle until the producer reaches WB: up to 2 cycles.

Decomposition:
- Shared package hazard_pkg:
  - typedef stage_entry_t {valid, rd, wb_en, from_mem}.
  - enum fwd_sel_t {FWD_REG=0, FWD_MEM=1, FWD_WB=2}.
  - constant REG_ZERO=0.
- One natural sub-module, hazard_match: given an entry plus rs and use, produces the match bit. Instantiated once per stage per source.

Test Plan:
- addi x1 then add x2,x1,x3 back-to-back, forwarding on → no stall; fwd_rs1_sel=1 in add's EX cycle. Forwarding off → stall_id high for 2 cycles, stall_cycles=2.
- lw x5 then add x6,x5,x5, forwarding on → exactly 1 cycle stall_id=bubble_ex=1; then fwd_rs1_sel=fwd_rs2_sel=2.
- Writer to x0 followed by a reader of x0 → no stall; fwd sels 0 under both macro settings.
- ex_redirect=1 while the ID instruction has a load-use hazard → flush_id=1, bubble_ex=1, stall_id=0; flush_count increments by 1.
- mem_busy held 3 cycles during a pending load-use stall → freeze=1 for 3 cycles with all state and counters held; then the stall resolves in 1 cycle.
- rst pulsed during a freeze → next cycle all outputs 0 and no tracking entry matches.
